i2c_target: RTL

//  I2C target (slave) counterpart to the on-chip I2C master: responds to one 7-bit address and exposes a

---
 rtl/i2c_target.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// i2c_target: 7-bit addressed I2C target exposing a byte register file with
// pointer-based writes and auto-incrementing reads.  Revision: 1.0
// ============================================================================
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         DEPTH    = 16,
  parameter int         HOLD_CYC = 8,
  localparam int        AW       = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_scl,
  inout  wire           io_sda,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_wr_stb,
  output logic [AW-1:0] o_wr_idx,
  output logic [7:0]    o_wr_dat,
  output logic          o_busy
);

  localparam int HW = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_WR_BYTE  = 3'd3,
    S_WR_ACK   = 3'd4,
    S_RD_BYTE  = 3'd5,
    S_RD_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  state_t        r_state;
  logic [1:0]    r_scl_sync;
  logic [1:0]    r_sda_sync;
  logic          r_scl_d;
  logic          r_sda_d;
  logic          r_sda_oe;
  logic          r_pend;
  logic          r_pend_oe;
  logic [HW-1:0] r_hcnt;
  logic [2:0]    r_bitcnt;
  logic [6:0]    r_shift;
  logic          r_rw;
  logic          r_ackf;
  logic          r_first;
  logic [AW-1:0] r_ptr;
  logic [7:0]    r_regs [DEPTH];
  logic [7:0]    r_rd_data;
  logic          r_wr_stb;
  logic [AW-1:0] r_wr_idx;
  logic [7:0]    r_wr_dat;
  logic          r_busy;

  logic          w_scl;
  logic          w_sda;
  logic          w_rise;
  logic          w_fall;
  logic          w_start;
  logic          w_stop;
  logic [7:0]    w_byte;

  assign io_sda  = r_sda_oe ? 1'b0 : 1'bz;

  assign w_scl   = r_scl_sync[1];
  assign w_sda   = r_sda_sync[1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & ~r_sda_d & w_sda;
  assign w_byte  = {r_shift, w_sda};

  assign o_rd_data = r_rd_data;
  assign o_wr_stb  = r_wr_stb;
  assign o_wr_idx  = r_wr_idx;
  assign o_wr_dat  = r_wr_dat;
  assign o_busy    = r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], io_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  // SDA changes are always deferred through r_pend so that the line moves
  // only HOLD_CYC cycles after the detected SCL fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_sda_oe  <= 1'b0;
      r_pend    <= 1'b0;
      r_pend_oe <= 1'b0;
      r_hcnt    <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_rw      <= 1'b0;
      r_ackf    <= 1'b0;
      r_first   <= 1'b0;
      r_ptr     <= '0;
      r_rd_data <= '0;
      r_wr_stb  <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_dat  <= '0;
      r_busy    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      r_wr_stb  <= 1'b0;
      r_rd_data <= r_regs[i_rd_addr];

      if (r_pend) begin
        if (r_hcnt == '0) begin
          r_sda_oe <= r_pend_oe;
          r_pend   <= 1'b0;
        end else begin
          r_hcnt <= r_hcnt - 1'b1;
        end
      end

      if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= '0;
        r_busy   <= 1'b0;
        r_pend   <= 1'b0;
        r_sda_oe <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_pend   <= 1'b0;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_rise) begin
              r_shift  <= w_byte[6:0];
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                if (r_shift == DEV_ADDR) begin
                  r_state <= S_ADDR_ACK;
                  r_busy  <= 1'b1;
                  r_rw    <= w_sda;
                  r_ackf  <= 1'b0;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
            end
          end

          S_ADDR_ACK: begin
            if (w_fall) begin
              r_pend <= 1'b1;
              r_hcnt <= HOLD_INIT;
              if (!r_ackf) begin
                r_ackf    <= 1'b1;
                r_pend_oe <= 1'b1;
              end else if (r_rw) begin
                r_shift   <= r_regs[r_ptr][6:0];
                r_pend_oe <= ~r_regs[r_ptr][7];
                r_bitcnt  <= '0;
                r_state   <= S_RD_BYTE;
              end else begin
                r_pend_oe <= 1'b0;
                r_first   <= 1'b1;
                r_bitcnt  <= '0;
                r_state   <= S_WR_BYTE;
              end
            end
          end

          S_WR_BYTE: begin
            if (w_rise) begin
              r_shift  <= w_byte[6:0];
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_state <= S_WR_ACK;
                r_ackf  <= 1'b0;
                if (r_first) begin
                  r_first <= 1'b0;
                  r_ptr   <= w_byte[AW-1:0];
                end else begin
                  r_regs[r_ptr] <= w_byte;
                  r_wr_stb      <= 1'b1;
                  r_wr_idx      <= r_ptr;
                  r_wr_dat      <= w_byte;
                  r_ptr         <= r_ptr + AW'(1);
                end
              end
            end
          end

          S_WR_ACK: begin
            if (w_fall) begin
              r_pend <= 1'b1;
              r_hcnt <= HOLD_INIT;
              if (!r_ackf) begin
                r_ackf    <= 1'b1;
                r_pend_oe <= 1'b1;
              end else begin
                r_pend_oe <= 1'b0;
                r_bitcnt  <= '0;
                r_state   <= S_WR_BYTE;
              end
            end
          end

          S_RD_BYTE: begin
            if (w_fall) begin
              r_pend <= 1'b1;
              r_hcnt <= HOLD_INIT;
              if (r_bitcnt == 3'd7) begin
                r_pend_oe <= 1'b0;
                r_ptr     <= r_ptr + AW'(1);
                r_ackf    <= 1'b0;
                r_state   <= S_RD_ACK;
              end else begin
                r_pend_oe <= ~r_shift[6];
                r_shift   <= {r_shift[5:0], 1'b0};
                r_bitcnt  <= r_bitcnt + 3'd1;
              end
            end
          end

          S_RD_ACK: begin
            // r_ackf records that the master ACKed on the 9th rise.
            if (w_rise) begin
              if (!w_sda) r_ackf  <= 1'b1;
              else        r_state <= S_IGNORE;
            end else if (w_fall && r_ackf) begin
              r_pend    <= 1'b1;
              r_hcnt    <= HOLD_INIT;
              r_shift   <= r_regs[r_ptr][6:0];
              r_pend_oe <= ~r_regs[r_ptr][7];
              r_bitcnt  <= '0;
              r_state   <= S_RD_BYTE;
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
